// File: rtl/sr_la_shift_reg.sv
// sr_la_shift_reg: WIDTH-bit shift register in the Caravel user area.
// Firmware controls it entirely through the logic analyzer (LA) bus.
// Operations are triggered by rising edges of LA strobes, so one slow
// firmware write produces exactly one operation. The serial output and
// the done flag are also exported on user GPIO 8 and 9.
module sr_la_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         resetb,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  output logic [37:0]  io_out,
  output logic [37:0]  io_oeb
);

  // LA input bit positions.
  localparam int LA_SHIFT   = 0;
  localparam int LA_SERIAL  = 1;
  localparam int LA_LOAD    = 2;
  localparam int LA_CLEAR   = 3;
  localparam int LA_LOADVAL = 32;

  // LA output bit positions.
  localparam int LA_SOUT  = 64;
  localparam int LA_DONE  = 65;
  localparam int LA_COUNT = 66;

  // GPIO pads owned by this block.
  localparam int IO_SOUT = 8;
  localparam int IO_DONE = 9;

  // The shift counter saturates at WIDTH (at most 32), so 6 bits suffice.
  localparam int          CNT_W   = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  // Only pads 8 and 9 are outputs; checkbits, flash and UART pads (0..7)
  // and every other pad stay tri-stated.
  localparam logic [37:0] IO_OEB_VAL = ~((38'd1 << IO_SOUT) | (38'd1 << IO_DONE));

  // One operation per cycle, chosen by priority clear > load > shift.
  typedef enum logic [1:0] {
    OP_NONE,
    OP_CLEAR,
    OP_LOAD,
    OP_SHIFT
  } op_e;

  // LA inputs after output-enable gating: a bit counts only when
  // management actually drives it.
  logic [127:0]     w_la_in;
  logic             w_shift_stb;
  logic             w_load_stb;
  logic             w_clear_stb;
  logic             w_serial_in;
  logic [WIDTH-1:0] w_load_val;

  // Strobe history for edge detection.
  logic r_shift_q;
  logic r_load_q;
  logic r_clear_q;

  logic w_shift_rise;
  logic w_load_rise;
  logic w_clear_rise;
  op_e  w_op;

  // Architectural state.
  logic [WIDTH-1:0] r_sr;
  logic             r_serial_out;
  logic [CNT_W-1:0] r_count;
  logic             r_done;

  logic [CNT_W-1:0] w_count_inc;

  // Unused LA inputs are collected here so the intent is explicit.
  logic w_unused;

  assign w_la_in     = la_data_in & ~la_oenb;
  assign w_shift_stb = w_la_in[LA_SHIFT];
  assign w_serial_in = w_la_in[LA_SERIAL];
  assign w_load_stb  = w_la_in[LA_LOAD];
  assign w_clear_stb = w_la_in[LA_CLEAR];
  assign w_load_val  = w_la_in[LA_LOADVAL +: WIDTH];

  assign w_unused = ^{w_la_in[127:LA_LOADVAL+WIDTH], w_la_in[LA_LOADVAL-1:LA_CLEAR+1]};

  assign w_shift_rise = w_shift_stb & ~r_shift_q;
  assign w_load_rise  = w_load_stb  & ~r_load_q;
  assign w_clear_rise = w_clear_stb & ~r_clear_q;

  // Count after one more shift, holding at WIDTH once reached.
  assign w_count_inc = (r_count == CNT_MAX) ? CNT_MAX : r_count + CNT_W'(1);

  // Register each gated strobe once; history clears on reset so a strobe
  // already high at reset release produces one edge on the first clock.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_shift_q <= 1'b0;
      r_load_q  <= 1'b0;
      r_clear_q <= 1'b0;
    end else begin
      r_shift_q <= w_shift_stb;
      r_load_q  <= w_load_stb;
      r_clear_q <= w_clear_stb;
    end
  end

  // Select the single operation for this cycle by priority.
  always_comb begin
    // NOTE: default first so every path assigns w_op and no latch forms.
    w_op = OP_NONE;
    if (w_clear_rise) begin
      w_op = OP_CLEAR;
    end else if (w_load_rise) begin
      w_op = OP_LOAD;
    end else if (w_shift_rise) begin
      w_op = OP_SHIFT;
    end
  end

  // Apply the selected operation to the shift register state.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_sr         <= '0;
      r_serial_out <= 1'b0;
      r_count      <= '0;
      r_done       <= 1'b0;
    end else begin
      unique case (w_op)
        OP_CLEAR: begin
          r_sr    <= '0;
          r_count <= '0;
          r_done  <= 1'b0;
        end
        OP_LOAD: begin
          r_sr    <= w_load_val;
          r_count <= '0;
          r_done  <= 1'b0;
        end
        OP_SHIFT: begin
          // Serial output is the bit that falls off the top (MSB first).
          r_serial_out <= r_sr[WIDTH-1];
          r_sr         <= {r_sr[WIDTH-2:0], w_serial_in};
          r_count      <= w_count_inc;
          // Sticky until the next clear/load; shifts continue past it.
          r_done       <= r_done | (w_count_inc == CNT_MAX);
        end
        default: begin
        end
      endcase
    end
  end

  // LA readback built from registers only; no path from la_data_in.
  always_comb begin
    la_data_out                        = '0;
    la_data_out[WIDTH-1:0]             = r_sr;
    la_data_out[LA_SOUT]               = r_serial_out;
    la_data_out[LA_DONE]               = r_done;
    la_data_out[LA_COUNT +: CNT_W]     = r_count;
  end

  // GPIO: serial output and done flag on pads 8 and 9.
  always_comb begin
    io_out          = '0;
    io_out[IO_SOUT] = r_serial_out;
    io_out[IO_DONE] = r_done;
    io_oeb          = IO_OEB_VAL;
  end

endmodule

// File: tb/tb_sr_la_shift_reg.sv
// Directed testbench for sr_la_shift_reg: a vector table of single
// operations plus hand-written multi-cycle sequences.
module tb_sr_la_shift_reg;

  localparam logic [37:0] EXP_OEB = 38'h3F_FFFF_FCFF;

  typedef enum logic [1:0] {
    T_CLEAR,
    T_LOAD,
    T_SHIFT
  } top_e;

  typedef struct {
    top_e        op;
    logic        si;
    logic [31:0] load_val;
    logic [31:0] exp_sr;
    logic [5:0]  exp_count;
    logic        exp_done;
    logic        exp_sout;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [127:0] la_in;
  logic [127:0] la_oenb;
  logic [127:0] la_out;
  logic [37:0]  io_out;
  logic [37:0]  io_oeb;

  int n_tests;
  int n_fail;

  sr_la_shift_reg #(.WIDTH(32)) dut (
    .clock      (clk),
    .resetb     (rst_n),
    .la_data_in (la_in),
    .la_oenb    (la_oenb),
    .la_data_out(la_out),
    .io_out     (io_out),
    .io_oeb     (io_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence never returns.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] sr, input logic [5:0] cnt,
                             input logic done, input logic sout);
    check({tag, " sr"},    128'(la_out[31:0]),  128'(sr));
    check({tag, " count"}, 128'(la_out[71:66]), 128'(cnt));
    check({tag, " done"},  128'(la_out[65]),    128'(done));
    check({tag, " sout"},  128'(la_out[64]),    128'(sout));
  endtask

  // Raise one strobe for a cycle, then drop it for a cycle; the operation
  // lands on the posedge inside the first cycle. Called at a negedge.
  task automatic pulse(input int idx);
    la_in[idx] = 1'b1;
    @(negedge clk);
    la_in[idx] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_op(input top_e op, input logic si, input logic [31:0] lv);
    case (op)
      T_CLEAR: pulse(3);
      T_LOAD: begin
        la_in[63:32] = lv;
        pulse(2);
      end
      default: begin
        la_in[1] = si;
        pulse(0);
      end
    endcase
  endtask

  vec_t vecs[11];

  initial begin
    logic [31:0] m_sr;
    logic        m_sout;
    logic [1:0]  mprj_fw;

    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{T_CLEAR, 1'b0, 32'h0,         32'h0000_0000, 6'd0, 1'b0, 1'b0};
    vecs[1]  = '{T_LOAD,  1'b0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 6'd0, 1'b0, 1'b0};
    vecs[2]  = '{T_SHIFT, 1'b0, 32'h0,         32'h4B4A_1E1E, 6'd1, 1'b0, 1'b1};
    vecs[3]  = '{T_SHIFT, 1'b1, 32'h0,         32'h9694_3C3D, 6'd2, 1'b0, 1'b0};
    vecs[4]  = '{T_CLEAR, 1'b0, 32'h0,         32'h0000_0000, 6'd0, 1'b0, 1'b0};
    vecs[5]  = '{T_SHIFT, 1'b1, 32'h0,         32'h0000_0001, 6'd1, 1'b0, 1'b0};
    vecs[6]  = '{T_SHIFT, 1'b1, 32'h0,         32'h0000_0003, 6'd2, 1'b0, 1'b0};
    vecs[7]  = '{T_SHIFT, 1'b0, 32'h0,         32'h0000_0006, 6'd3, 1'b0, 1'b0};
    vecs[8]  = '{T_SHIFT, 1'b1, 32'h0,         32'h0000_000D, 6'd4, 1'b0, 1'b0};
    vecs[9]  = '{T_LOAD,  1'b0, 32'h1234_5678, 32'h1234_5678, 6'd0, 1'b0, 1'b0};
    vecs[10] = '{T_SHIFT, 1'b1, 32'h0,         32'h2468_ACF1, 6'd1, 1'b0, 1'b0};

    // Reset: strobes low, management drives bits 0..3 and 32..63.
    rst_n   = 1'b0;
    la_in   = '0;
    la_oenb = ~{64'h0, 32'hFFFF_FFFF, 32'h0000_000F};
    repeat (3) @(negedge clk);
    check("reset la_out", la_out, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset la_out", la_out, 128'h0);
    check("post-reset io_out", 128'(io_out), 128'h0);
    check("post-reset io_oeb", 128'(io_oeb), 128'(EXP_OEB));

    // Table of single operations.
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].op, vecs[i].si, vecs[i].load_val);
      check_state($sformatf("vec%0d", i), vecs[i].exp_sr, vecs[i].exp_count,
                  vecs[i].exp_done, vecs[i].exp_sout);
    end

    // Load A5A50F0F and shift it all out MSB first with serial_in=0.
    do_op(T_LOAD, 1'b0, 32'hA5A5_0F0F);
    m_sr = 32'hA5A5_0F0F;
    for (int i = 0; i < 32; i++) begin
      m_sout = m_sr[31];
      m_sr   = {m_sr[30:0], 1'b0};
      do_op(T_SHIFT, 1'b0, 32'h0);
      check($sformatf("shiftout%0d sout", i), 128'(la_out[64]), 128'(m_sout));
      check($sformatf("shiftout%0d io8", i), 128'(io_out[8]), 128'(m_sout));
    end
    check_state("shiftout end", 32'h0, 6'd32, 1'b1, 1'b1);
    check("shiftout io9", 128'(io_out[9]), 128'h1);
    // One more shift past done: count saturates, done holds.
    do_op(T_SHIFT, 1'b1, 32'h0);
    check_state("past done", 32'h1, 6'd32, 1'b1, 1'b0);

    // Held shift strobe fires once.
    do_op(T_CLEAR, 1'b0, 32'h0);
    la_in[1] = 1'b1;
    la_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    check_state("held shift", 32'h1, 6'd1, 1'b0, 1'b0);
    // Forcing the held strobe off via la_oenb: a falling edge only.
    la_oenb[0] = 1'b1;
    repeat (2) @(negedge clk);
    check_state("oenb fall", 32'h1, 6'd1, 1'b0, 1'b0);
    // Load strobe toggled while its oenb bit is 1 is ignored.
    la_oenb[2] = 1'b1;
    do_op(T_LOAD, 1'b0, 32'hDEAD_BEEF);
    check_state("oenb load gated", 32'h1, 6'd1, 1'b0, 1'b0);
    la_in[0]   = 1'b0;
    la_oenb[0] = 1'b0;
    la_oenb[2] = 1'b0;
    @(negedge clk);

    // Priority: clear, load and shift edges together -> clear wins.
    la_in[63:32] = 32'hFFFF_0000;
    la_in[3:0]   = 4'b1111;
    @(negedge clk);
    la_in[3:0] = 4'b0000;
    @(negedge clk);
    check_state("prio all", 32'h0, 6'd0, 1'b0, 1'b0);
    // Load and shift together -> load only, no shift.
    la_in[2] = 1'b1;
    la_in[0] = 1'b1;
    @(negedge clk);
    la_in[2] = 1'b0;
    la_in[0] = 1'b0;
    @(negedge clk);
    check_state("prio load", 32'hFFFF_0000, 6'd0, 1'b0, 1'b0);

    // Reset mid-operation with shift strobe rising: aborts immediately.
    la_in[1] = 1'b1;
    la_in[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("async reset sr", 128'(la_out[31:0]), 128'h0);
    @(negedge clk);
    check_state("in reset", 32'h0, 6'd0, 1'b0, 1'b0);
    // Strobe still high at release fires once on the first clock.
    rst_n = 1'b1;
    @(negedge clk);
    check_state("release fire", 32'h1, 6'd1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_state("release hold", 32'h1, 6'd1, 1'b0, 1'b0);
    la_in[0] = 1'b0;
    @(negedge clk);

    // System flow as firmware would run it.
    mprj_fw = 2'b01;
    do_op(T_LOAD, 1'b0, 32'h1234_5678);
    for (int i = 0; i < 8; i++) do_op(T_SHIFT, 1'b1, 32'h0);
    check("system sr", 128'(la_out[31:0]), 128'h3456_78FF);
    check("system count", 128'(la_out[71:66]), 128'd8);
    check("system pads 0..7 undriven", 128'(io_oeb[7:0]), 128'hFF);
    mprj_fw = 2'b10;
    check("system mprj_io[1:0] not driven", 128'(io_out[1:0] & ~io_oeb[1:0]), 128'h0);
    if (mprj_fw != 2'b10) $display("firmware progress code %0b", mprj_fw);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
